// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler: queues SEQ writeback requests (up to two register writes each)
// and drains them one write per cycle into a single-write-port register file.
module rf_wb_scheduler #(
  parameter int          DEPTH  = 2,
  parameter int          DATA_W = 64,
  parameter logic [3:0]  RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_dstE,
  input  logic [DATA_W-1:0] in_valE,
  input  logic [3:0]        in_dstM,
  input  logic [DATA_W-1:0] in_valM,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_a,
  input  logic [3:0]        rd_b,
  output logic              haz_a,
  output logic              haz_b,
  output logic              busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  pende_q, pende_d;
  logic [DEPTH-1:0]  pendm_q, pendm_d;

  logic [3:0]        dste_q [DEPTH];
  logic [3:0]        dstm_q [DEPTH];
  logic [DATA_W-1:0] vale_q [DEPTH];
  logic [DATA_W-1:0] valm_q [DEPTH];

  logic non_empty;
  logic head_pe, head_pm;
  logic issue_e, issue_m, retire;
  logic push, enq_pe, enq_pm, enq_keep;

  assign non_empty = (count_q != '0);
  assign in_ready  = (count_q < DEPTH_C);
  assign busy      = non_empty;

  assign head_pe = pende_q[rd_ptr_q];
  assign head_pm = pendm_q[rd_ptr_q];
  assign issue_e = non_empty && head_pe;
  assign issue_m = non_empty && !head_pe && head_pm;
  assign retire  = (issue_e && !head_pm) || issue_m;

  // On dstE == dstM the memory value wins, so the ALU write is never queued.
  assign push     = in_valid && in_ready;
  assign enq_pe   = (in_dstE != RNONE) && (in_dstE != in_dstM);
  assign enq_pm   = (in_dstM != RNONE);
  assign enq_keep = push && (enq_pe || enq_pm);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (issue_e) begin
      wr_en   = 1'b1;
      wr_addr = dste_q[rd_ptr_q];
      wr_data = vale_q[rd_ptr_q];
    end else if (issue_m) begin
      wr_en   = 1'b1;
      wr_addr = dstm_q[rd_ptr_q];
      wr_data = valm_q[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = enq_keep ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = retire   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (enq_keep && !retire)      count_d = count_q + CW'(1);
    else if (!enq_keep && retire) count_d = count_q - CW'(1);
    pende_d = pende_q;
    pendm_d = pendm_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr_q == PW'(i)) begin
        if (retire) begin
          pende_d[i] = 1'b0;
          pendm_d[i] = 1'b0;
        end else if (issue_e) begin
          pende_d[i] = 1'b0;
        end
      end
      // The write slot never equals a live head, since push only happens below DEPTH.
      if (enq_keep && (wr_ptr_q == PW'(i))) begin
        pende_d[i] = enq_pe;
        pendm_d[i] = enq_pm;
      end
    end
  end

  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((pende_q[i] && dste_q[i] == rd_a) || (pendm_q[i] && dstm_q[i] == rd_a))
        haz_a = 1'b1;
      if ((pende_q[i] && dste_q[i] == rd_b) || (pendm_q[i] && dstm_q[i] == rd_b))
        haz_b = 1'b1;
    end
    if (rd_a == RNONE) haz_a = 1'b0;
    if (rd_b == RNONE) haz_b = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pende_q  <= '0;
      pendm_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pende_q  <= pende_d;
      pendm_q  <= pendm_d;
    end
  end

  // Payload storage needs no reset; the pending bits qualify it.
  always_ff @(posedge clk) begin
    if (enq_keep) begin
      dste_q[wr_ptr_q] <= in_dstE;
      dstm_q[wr_ptr_q] <= in_dstM;
      vale_q[wr_ptr_q] <= in_valE;
      valm_q[wr_ptr_q] <= in_valM;
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler (DEPTH=2, DATA_W=64).
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_dstE, in_dstM;
  logic [63:0] in_valE, in_valM;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  rd_a, rd_b;
  logic        haz_a, haz_b, busy;

  int tests = 0;
  int fails = 0;

  rf_wb_scheduler #(.DEPTH(2), .DATA_W(64), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dstE(in_dstE), .in_valE(in_valE), .in_dstM(in_dstM), .in_valM(in_valM),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_a(rd_a), .rd_b(rd_b), .haz_a(haz_a), .haz_b(haz_b), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input string tag, input logic en, input logic [3:0] addr,
                           input logic [63:0] data);
    check({tag, ".wr_en"},   {63'd0, wr_en},   {63'd0, en});
    check({tag, ".wr_addr"}, {60'd0, wr_addr}, {60'd0, addr});
    check({tag, ".wr_data"}, wr_data,          data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] de, input logic [63:0] ve,
                     input logic [3:0] dm, input logic [63:0] vm);
    in_valid = 1'b1;
    in_dstE  = de;
    in_valE  = ve;
    in_dstM  = dm;
    in_valM  = vm;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_dstE  = 4'hF;
    in_dstM  = 4'hF;
    in_valE  = '0;
    in_valM  = '0;
    rd_a     = 4'hF;
    rd_b     = 4'hF;

    // In reset
    #3;
    expect_wr("rst", 1'b0, 4'h0, 64'h0);
    check("rst.busy",     {63'd0, busy},     64'd0);
    check("rst.in_ready", {63'd0, in_ready}, 64'd1);
    check("rst.haz_a",    {63'd0, haz_a},    64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single E write; the incoming request itself is not a hazard
    req(4'd3, 64'h55, 4'hF, 64'h0);
    rd_a = 4'd3;
    check("single.in_ready", {63'd0, in_ready}, 64'd1);
    check("single.haz_pre",  {63'd0, haz_a},    64'd0);
    tick();
    in_valid = 1'b0;
    expect_wr("single", 1'b1, 4'd3, 64'h55);
    check("single.haz_a", {63'd0, haz_a}, 64'd1);
    check("single.busy",  {63'd0, busy},  64'd1);
    tick();
    check("single.busy_after", {63'd0, busy}, 64'd0);
    expect_wr("single.idle", 1'b0, 4'h0, 64'h0);
    check("single.haz_clr", {63'd0, haz_a}, 64'd0);

    // popq: E then M, hazards track each piece
    req(4'd4, 64'h108, 4'd2, 64'hAB);
    rd_a = 4'd2;
    rd_b = 4'd4;
    tick();
    in_valid = 1'b0;
    expect_wr("popq.e", 1'b1, 4'd4, 64'h108);
    check("popq.e.haz_a", {63'd0, haz_a}, 64'd1);
    check("popq.e.haz_b", {63'd0, haz_b}, 64'd1);
    tick();
    expect_wr("popq.m", 1'b1, 4'd2, 64'hAB);
    check("popq.m.haz_a", {63'd0, haz_a}, 64'd1);
    check("popq.m.haz_b", {63'd0, haz_b}, 64'd0);
    tick();
    expect_wr("popq.idle", 1'b0, 4'h0, 64'h0);
    check("popq.haz_a_clr", {63'd0, haz_a}, 64'd0);
    check("popq.busy",      {63'd0, busy},  64'd0);
    rd_a = 4'hF;
    rd_b = 4'hF;

    // Collision: M wins, single write
    req(4'd4, 64'h110, 4'd4, 64'h77);
    tick();
    in_valid = 1'b0;
    expect_wr("coll", 1'b1, 4'd4, 64'h77);
    tick();
    expect_wr("coll.idle", 1'b0, 4'h0, 64'h0);
    check("coll.busy", {63'd0, busy}, 64'd0);

    // No-op request is accepted and dropped
    req(4'hF, 64'h1, 4'hF, 64'h2);
    check("noop.in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("noop.busy", {63'd0, busy}, 64'd0);
    expect_wr("noop", 1'b0, 4'h0, 64'h0);

    // Three back-to-back two-write requests fill the two-entry FIFO
    req(4'd1, 64'hA1, 4'd5, 64'hA5);
    check("full.rdy0", {63'd0, in_ready}, 64'd1);
    tick();
    req(4'd6, 64'hB6, 4'd7, 64'hB7);
    check("full.rdy1", {63'd0, in_ready}, 64'd1);
    expect_wr("full.w1", 1'b1, 4'd1, 64'hA1);
    tick();
    req(4'd8, 64'hC8, 4'd9, 64'hC9);
    check("full.rdy2", {63'd0, in_ready}, 64'd0);
    expect_wr("full.w2", 1'b1, 4'd5, 64'hA5);
    tick();
    check("full.rdy3", {63'd0, in_ready}, 64'd1);
    expect_wr("full.w3", 1'b1, 4'd6, 64'hB6);
    tick();
    in_valid = 1'b0;
    check("full.busy", {63'd0, busy}, 64'd1);
    expect_wr("full.w4", 1'b1, 4'd7, 64'hB7);
    tick();
    expect_wr("full.w5", 1'b1, 4'd8, 64'hC8);
    tick();
    expect_wr("full.w6", 1'b1, 4'd9, 64'hC9);
    tick();
    expect_wr("full.idle", 1'b0, 4'h0, 64'h0);
    check("full.busy_end", {63'd0, busy}, 64'd0);

    // Async reset between the two writes of a popq
    req(4'd4, 64'h108, 4'd2, 64'hAB);
    rd_a = 4'd2;
    tick();
    in_valid = 1'b0;
    expect_wr("ar.e", 1'b1, 4'd4, 64'h108);
    tick();
    expect_wr("ar.m", 1'b1, 4'd2, 64'hAB);
    #1;
    rst_n = 1'b0;
    #1;
    expect_wr("ar.in_rst", 1'b0, 4'h0, 64'h0);
    check("ar.busy_rst",  {63'd0, busy},  64'd0);
    check("ar.haz_rst",   {63'd0, haz_a}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar.busy",     {63'd0, busy},     64'd0);
    check("ar.in_ready", {63'd0, in_ready}, 64'd1);
    expect_wr("ar.post", 1'b0, 4'h0, 64'h0);
    tick();
    expect_wr("ar.post2", 1'b0, 4'h0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Write-port scheduler between the SEQ writeback stage and a single-write-port 15-entry register file.
- Accepts writeback requests carrying up to two writes: dstE/valE from the ALU and dstM/valM from memory. Examples: popq writes %rsp and rA; mrmovq writes rA.
- Buffers requests in a small FIFO and issues at most one register write per cycle.
- Reports pending-write hazards on two decode read addresses so the control unit can stall decode.

Parameters:
- DEPTH, 2, request FIFO entries; power of two, >=2.
- DATA_W, 64, register data width.
- RNONE, 4'hF, register ID meaning "no register".

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  writeback request valid.
- in_ready  output  1  scheduler can accept a request this cycle.
- in_dstE  input  4  destination for valE; RNONE = none.
- in_valE  input  DATA_W  ALU result.
- in_dstM  input  4  destination for valM; RNONE = none.
- in_valM  input  DATA_W  memory read data.
- wr_en  output  1  register file write strobe.
- wr_addr  output  4  register file write address.
- wr_data  output  DATA_W  register file write data.
- rd_a  input  4  decode source A register ID.
- rd_b  input  4  decode source B register ID.
- haz_a  output  1  a queued write targets rd_a.
- haz_b  output  1  a queued write targets rd_b.
- busy  output  1  FIFO non-empty.

Behaviour:
- Reset: rst_n low asynchronously clears wr_ptr, rd_ptr, count and all per-entry E/M pending bits. While in reset and after it: wr_en=0, wr_addr=0, wr_data=0, busy=0, haz_a=haz_b=0, in_ready=1. Reset mid-operation discards all queued writes; none are issued.
- Handshake: transfer occurs when in_valid && in_ready at posedge. in_ready = (count < DEPTH), combinational from state only. There is no same-cycle pass-through when full.
- Enqueue normalisation, applied at transfer:
  - pendE = (in_dstE != RNONE) && (in_dstE != in_dstM); on a collision M wins, matching popq %rsp semantics.
  - pendM = (in_dstM != RNONE).
  - If neither is pending, the request is accepted and dropped: count is unchanged and no write is issued.
- Issue: wr_en/wr_addr/wr_data are driven combinationally from the FIFO head. The regfile samples them at the next posedge.
  - Head pendE set: drive dstE/valE, clear pendE at the posedge.
  - Otherwise head pendM set: drive dstM/valM, clear pendM at the posedge.
  - The head retires (rd_ptr++, count--) on the posedge that issues its last pending write.
- Resulting latency: an entry accepted at edge t issues wr_en in cycle t..t+1 and retires at edge t+1 (one write) or t+2 (two writes) when it is at the head.
- Empty FIFO: wr_en=0, wr_addr=0, wr_data=0.
- Simultaneous enqueue and retire: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Hazards:
  - haz_a=1 iff rd_a != RNONE and some valid entry has pendE with dstE==rd_a or pendM with dstM==rd_a. haz_b is the same for rd_b.
  - Combinational. It includes the piece being written in the current cycle and excludes the incoming request in the same cycle.
- busy = (count != 0).
- Throughput: one write per cycle. Two-write requests halve request throughput; sustained back-to-back two-write requests fill the FIFO and deassert in_ready.

Test Plan:
- Reset and single write: reset, then request dstE=3 valE=0x55 dstM=F. Required: in_ready=1; next cycle wr_en=1, wr_addr=3, wr_data=0x55; the following cycle busy=0.
- popq ordering: dstE=4 valE=0x108, dstM=2 valM=0xAB. Required: write 4<-0x108, then 2<-0xAB on consecutive cycles; haz_a with rd_a=2 stays 1 until the second write's edge.
- Collision: dstE=4 valE=0x110, dstM=4 valM=0x77. Required: exactly one write, 4<-0x77.
- No-op and full: request with dstE=dstM=F is accepted with no write and busy unchanged. Three back-to-back two-write requests with DEPTH=2 deassert in_ready on the third until the head retires; all 6 writes issue in order.
- Async reset mid-drain: assert rst_n=0 between the two writes of a popq. Required: wr_en drops immediately; after release busy=0, in_ready=1, and no residual write appears.
